lvds_ddr_serializer: RTL and testbench

//  Upstream feeder for an ODDR + TLVDS_OBUF output pair. Accepts parallel words over a

---
 rtl/lvds_tx_pkg.sv | 9 +
 rtl/lvds_ddr_shifter.sv | 49 ++++
 rtl/lvds_ddr_serializer.sv | 135 +++++++++++++
 tb/tb_lvds_ddr_serializer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_tx_pkg.sv
// Shared types and defaults for the LVDS DDR serializer.
package lvds_tx_pkg;

   typedef enum logic [1:0] {WARMUP, TRAIN, IDLE, DATA} tx_state_t;

   localparam int         DEF_WARMUP_CYC = 4;
   localparam logic [7:0] DEF_TRAIN_WORD = 8'hA5;

endpackage

// File: rtl/lvds_ddr_shifter.sv
// Word shift register and beat counter; drives the ODDR D0/D1 flops two bits per cycle.
module lvds_ddr_shifter #(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WORD_W-1:0] word,
   input  logic              shift,
   input  logic              hold,
   input  logic              hold_d0,
   input  logic              hold_d1,
   output logic              d0,
   output logic              d1,
   output logic              last_beat
);

   localparam int BW = $clog2(WORD_W/2);

   logic [WORD_W-3:0] sr;
   logic [BW-1:0]     beat;

   // Priority: a new word wins over shifting, shifting over the fixed hold pattern.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d0   <= 1'b0;
         d1   <= 1'b0;
         sr   <= '0;
         beat <= '0;
      end else if (load) begin
         d0   <= word[0];
         d1   <= word[1];
         sr   <= word[WORD_W-1:2];
         beat <= '0;
      end else if (shift) begin
         d0   <= sr[0];
         d1   <= sr[1];
         sr   <= sr >> 2;
         beat <= beat + BW'(1);
      end else if (hold) begin
         d0   <= hold_d0;
         d1   <= hold_d1;
         beat <= '0;
      end
   end

   assign last_beat = (beat == BW'(WORD_W/2 - 1));

endmodule

// File: rtl/lvds_ddr_serializer.sv
// Handshake front end and warm-up/training/idle sequencing for an ODDR + LVDS output pair.
module lvds_ddr_serializer import lvds_tx_pkg::*; #(
   parameter int              WORD_W      = 8,
   parameter int              WARMUP_CYC  = DEF_WARMUP_CYC,
   parameter logic [WORD_W-1:0] TRAIN_WORD = WORD_W'(DEF_TRAIN_WORD),
   parameter int              TRAIN_WORDS = 4,
   parameter logic            IDLE_D0     = 1'b0,
   parameter logic            IDLE_D1     = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              train_req,
   output logic              d0,
   output logic              d1,
   output logic              busy
);

   localparam int WCW = $clog2(WARMUP_CYC + 1);
   localparam int TCW = $clog2(TRAIN_WORDS + 1);

   generate
      if ((WORD_W % 2) != 0 || WORD_W < 4 || TRAIN_WORDS < 1) begin : g_bad_cfg
         $error("lvds_ddr_serializer: WORD_W must be even and >= 4, TRAIN_WORDS >= 1");
      end
   endgenerate

   tx_state_t         state, state_n;
   logic [WCW-1:0]    warm_cnt, warm_n;
   logic [TCW-1:0]    train_cnt, train_n;
   logic              train_pend, pend_n;
   logic              treq;

   logic              load, shift, hold, hold_d0, hold_d1, last_beat;
   logic [WORD_W-1:0] ld_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= WARMUP;
         warm_cnt   <= '0;
         train_cnt  <= '0;
         train_pend <= 1'b0;
      end else begin
         state      <= state_n;
         warm_cnt   <= warm_n;
         train_cnt  <= train_n;
         train_pend <= pend_n;
      end
   end

   // A request seen mid-word is remembered so it still wins at the word boundary.
   assign treq = train_req | train_pend;

   always_comb begin
      state_n  = state;
      warm_n   = warm_cnt;
      train_n  = train_cnt;
      pend_n   = train_pend;
      load     = 1'b0;
      ld_word  = in_data;
      shift    = 1'b0;
      hold     = 1'b0;
      hold_d0  = IDLE_D0;
      hold_d1  = IDLE_D1;
      in_ready = 1'b0;
      case (state)
         WARMUP: begin
            if (warm_cnt == WCW'(WARMUP_CYC - 1)) begin
               load    = 1'b1;
               ld_word = TRAIN_WORD;
               train_n = '0;
               state_n = TRAIN;
            end else begin
               hold    = 1'b1;
               hold_d0 = 1'b0;
               hold_d1 = 1'b0;
               warm_n  = warm_cnt + WCW'(1);
            end
         end
         TRAIN: begin
            if (!last_beat) begin
               shift = 1'b1;
            end else if (train_cnt == TCW'(TRAIN_WORDS - 1)) begin
               hold    = 1'b1;
               state_n = IDLE;
            end else begin
               load    = 1'b1;
               ld_word = TRAIN_WORD;
               train_n = train_cnt + TCW'(1);
            end
         end
         IDLE, DATA: begin
            if (state == DATA && !last_beat) begin
               shift = 1'b1;
               if (train_req) pend_n = 1'b1;
            end else begin
               in_ready = !treq;
               if (treq) begin
                  load    = 1'b1;
                  ld_word = TRAIN_WORD;
                  train_n = '0;
                  pend_n  = 1'b0;
                  state_n = TRAIN;
               end else if (in_valid) begin
                  load    = 1'b1;
                  state_n = DATA;
               end else begin
                  hold    = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = WARMUP;
      endcase
   end

   assign busy = (state != IDLE);

   lvds_ddr_shifter #(.WORD_W(WORD_W)) u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .word      (ld_word),
      .shift     (shift),
      .hold      (hold),
      .hold_d0   (hold_d0),
      .hold_d1   (hold_d1),
      .d0        (d0),
      .d1        (d1),
      .last_beat (last_beat)
   );

endmodule

// File: tb/tb_lvds_ddr_serializer.sv
// Directed and randomized bench for lvds_ddr_serializer; inputs change and outputs are sampled on negedge.
module tb_lvds_ddr_serializer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       train_req;
   logic       d0, d1, busy;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   lvds_ddr_serializer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .train_req (train_req),
      .d0        (d0),
      .d1        (d1),
      .busy      (busy)
   );

   // Expects to be entered right after rst_n is released on a negedge.
   task automatic expect_warmup_and_training(input string tag);
      logic [7:0] tw;
      tw = 8'hA5;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if ({d0, d1, busy, in_ready} !== 4'b0010) begin
            fails++;
            $display("FAIL %s_warmup cyc %0d got d0=%b d1=%b busy=%b rdy=%b want 0 0 1 0",
                     tag, i, d0, d1, busy, in_ready);
         end
      end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({d0, d1, busy, in_ready} !== {tw[2*(i%4)], tw[2*(i%4)+1], 2'b10}) begin
            fails++;
            $display("FAIL %s_train beat %0d got d0=%b d1=%b busy=%b rdy=%b want %b %b 1 0",
                     tag, i, d0, d1, busy, in_ready, tw[2*(i%4)], tw[2*(i%4)+1]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({d0, d1, busy, in_ready} !== 4'b0101) begin
            fails++;
            $display("FAIL %s_idle cyc %0d got d0=%b d1=%b busy=%b rdy=%b want 0 1 0 1",
                     tag, i, d0, d1, busy, in_ready);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; train_req = 1'b0; in_data = 8'h00;
      repeat (2) @(negedge clk);
      checks++;
      if ({d0, d1, busy, in_ready} !== 4'b0010) begin
         fails++;
         $display("FAIL reset_state got d0=%b d1=%b busy=%b rdy=%b want 0 0 1 0", d0, d1, busy, in_ready);
      end
      // A training request during warm-up/training must not add a burst.
      train_req = 1'b1;
      rst_n = 1'b1;
      #1 train_req = 1'b0;
      expect_warmup_and_training("t1");
   endtask

   task automatic test_single_word();
      logic [7:0] w;
      w = 8'h1B;
      in_valid = 1'b1; in_data = w;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) in_valid = 1'b0;
         #1;
         checks++;
         if ({d0, d1, busy} !== {w[2*(k-1)], w[2*(k-1)+1], 1'b1}) begin
            fails++;
            $display("FAIL t2_pair beat %0d got d0=%b d1=%b busy=%b want %b %b 1",
                     k-1, d0, d1, busy, w[2*(k-1)], w[2*(k-1)+1]);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if ({d0, d1, busy} !== 3'b010) begin
         fails++;
         $display("FAIL t2_idle got d0=%b d1=%b busy=%b want 0 1 0", d0, d1, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ws;
      ws = 16'h00FF;
      in_valid = 1'b1; in_data = 8'hFF;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) in_data = 8'h00;
         if (k == 5) in_valid = 1'b0;
         #1;
         checks++;
         if ({d0, d1, busy} !== {ws[2*(k-1)], ws[2*(k-1)+1], 1'b1}) begin
            fails++;
            $display("FAIL t3_pair beat %0d got d0=%b d1=%b busy=%b want %b %b 1",
                     k-1, d0, d1, busy, ws[2*(k-1)], ws[2*(k-1)+1]);
         end
         checks++;
         if (in_ready !== (k == 4 || k == 8)) begin
            fails++;
            $display("FAIL t3_ready beat %0d got %b want %b", k-1, in_ready, (k == 4 || k == 8));
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if ({d0, d1, busy} !== 3'b010) begin
         fails++;
         $display("FAIL t3_idle got d0=%b d1=%b busy=%b want 0 1 0", d0, d1, busy);
      end
   endtask

   task automatic test_train_req();
      logic [7:0] w, tw;
      w = 8'h3C; tw = 8'hA5;
      in_valid = 1'b1; in_data = w;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) in_valid = 1'b0;
         if (k == 2) train_req = 1'b1;
         if (k == 3) begin
            train_req = 1'b0;
            in_valid  = 1'b1;
            in_data   = 8'h77;
         end
         #1;
         checks++;
         if ({d0, d1} !== {w[2*(k-1)], w[2*(k-1)+1]}) begin
            fails++;
            $display("FAIL t4_pair beat %0d got d0=%b d1=%b want %b %b",
                     k-1, d0, d1, w[2*(k-1)], w[2*(k-1)+1]);
         end
      end
      checks++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL t4_ready_last got %b want 0", in_ready);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({d0, d1, busy} !== {tw[2*(i%4)], tw[2*(i%4)+1], 1'b1}) begin
            fails++;
            $display("FAIL t4_train beat %0d got d0=%b d1=%b busy=%b want %b %b 1",
                     i, d0, d1, busy, tw[2*(i%4)], tw[2*(i%4)+1]);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if ({d0, d1, busy, in_ready} !== 4'b0101) begin
         fails++;
         $display("FAIL t4_idle got d0=%b d1=%b busy=%b rdy=%b want 0 1 0 1", d0, d1, busy, in_ready);
      end
   endtask

   task automatic test_reset_mid_word();
      in_valid = 1'b1; in_data = 8'h3F;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) in_valid = 1'b0;
      end
      #1;
      checks++;
      if ({d0, d1} !== 2'b11) begin
         fails++;
         $display("FAIL t5_beat2 got d0=%b d1=%b want 1 1", d0, d1);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({d0, d1, busy, in_ready} !== 4'b0010) begin
         fails++;
         $display("FAIL t5_async got d0=%b d1=%b busy=%b rdy=%b want 0 0 1 0", d0, d1, busy, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      expect_warmup_and_training("t5");
   endtask

   task automatic test_random();
      logic [1:0] expq[$];
      int  accepted, beats_seen;
      logic acc_prev;
      logic [1:0] e;
      accepted = 0; beats_seen = 0; acc_prev = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            beats_seen++;
            checks++;
            if ({d0, d1} !== e) begin
               fails++;
               $display("FAIL t6_pair cyc %0d got d0=%b d1=%b want %b %b", cyc, d0, d1, e[1], e[0]);
            end
         end else if (!busy) begin
            checks++;
            if ({d0, d1} !== 2'b01) begin
               fails++;
               $display("FAIL t6_idle cyc %0d got d0=%b d1=%b want 0 1", cyc, d0, d1);
            end
         end
         if (!(in_valid && !acc_prev)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
         end
         train_req = ($urandom_range(0, 47) == 0);
         #1;
         if (expq.size() > 0) begin
            checks++;
            if (in_ready !== 1'b0) begin
               fails++;
               $display("FAIL t6_ready_midword cyc %0d got %b want 0", cyc, in_ready);
            end
         end
         acc_prev = in_valid && in_ready;
         if (acc_prev) begin
            accepted++;
            for (int b = 0; b < 4; b++) expq.push_back({in_data[2*b], in_data[2*b+1]});
         end
      end
      in_valid = 1'b0; train_req = 1'b0;
      for (int cyc = 0; cyc < 8 && expq.size() > 0; cyc++) begin
         @(negedge clk);
         e = expq.pop_front();
         beats_seen++;
         checks++;
         if ({d0, d1} !== e) begin
            fails++;
            $display("FAIL t6_drain got d0=%b d1=%b want %b %b", d0, d1, e[1], e[0]);
         end
      end
      checks++;
      if (accepted < 100 || beats_seen != accepted * 4) begin
         fails++;
         $display("FAIL t6_counts got accepted=%0d beats=%0d want >=100 and beats=4*accepted",
                  accepted, beats_seen);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_train_req();
      test_reset_mid_word();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
